impulse_capture: RTL and testbench

- Writer side of the impulse-response memory that convolve_audio reads through read_addr/read_data.
- After a measurement stimulus is emitted, it watches incoming audio samples for onset. It records the distance in samples until onset as delay_length.
- It then writes impulse_length consecutive samples into IR BRAM and raises impulse_in_memory_complete, which gates convolution and delay in the downstream path.

---
 rtl/impulse_pkg.sv | 26 ++
 rtl/impulse_capture_onset_detector.sv | 13 +
 rtl/impulse_capture.sv | 160 ++++++++++++++++
 tb/tb_impulse_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/impulse_pkg.sv
// Shared types and helpers for the impulse-response capture path.
package impulse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        RECORDING = 2'd2,
        DONE      = 2'd3
    } capture_state_t;

    localparam int SAMPLE_W = 16;

    // |x| with -32768 saturating to 32767 so the result always fits 16 bits unsigned-positive.
    function automatic logic [SAMPLE_W-1:0] sat_abs16(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg_x;
        neg_x = $unsigned(-x);
        if (x[SAMPLE_W-1] && (x[SAMPLE_W-2:0] == '0)) begin
            return 16'h7FFF;
        end else if (x[SAMPLE_W-1]) begin
            return neg_x;
        end else begin
            return $unsigned(x);
        end
    endfunction

endpackage

// File: rtl/impulse_capture_onset_detector.sv
// Purely combinational onset test: saturating magnitude against a fixed threshold.
module onset_detector
    import impulse_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] onset_threshold = 16'd2000
) (
    input  logic signed [SAMPLE_W-1:0] audio_in,
    output logic                       is_onset
);

    assign is_onset = (sat_abs16(audio_in) >= onset_threshold);

endmodule

// File: rtl/impulse_capture.sv
// Waits for an acoustic onset after a stimulus, then streams impulse_length samples into IR BRAM.
module impulse_capture
    import impulse_pkg::*;
#(
    parameter int                  impulse_length  = 48000,
    parameter logic [SAMPLE_W-1:0] onset_threshold = 16'd2000,
    parameter logic [SAMPLE_W-1:0] max_delay       = 16'd24000
) (
    input  logic                       audio_clk,
    input  logic                       rst_in,
    input  logic                       start_capture,
    input  logic                       audio_trigger,
    input  logic signed [SAMPLE_W-1:0] audio_in,
    output logic [SAMPLE_W-1:0]        write_addr,
    output logic signed [SAMPLE_W-1:0] write_data,
    output logic                       write_enable,
    output logic [SAMPLE_W-1:0]        delay_length,
    output logic                       impulse_in_memory_complete,
    output logic                       capture_timeout,
    output logic                       busy
);

    // 17-bit sample counter so impulse_length = 65536 still reaches its last address.
    localparam logic [16:0]         last_sample = 17'(impulse_length - 1);
    localparam logic [SAMPLE_W-1:0] last_delay  = max_delay - 16'd1;

    capture_state_t state_reg, state_next;

    logic [SAMPLE_W-1:0]        delay_count_reg, delay_count_next;
    logic [16:0]                sample_count_reg, sample_count_next;
    logic [SAMPLE_W-1:0]        write_addr_reg, write_addr_next;
    logic signed [SAMPLE_W-1:0] write_data_reg, write_data_next;
    logic                       write_enable_reg, write_enable_next;
    logic [SAMPLE_W-1:0]        delay_length_reg, delay_length_next;
    logic                       complete_reg, complete_next;
    logic                       timeout_reg, timeout_next;
    logic                       is_onset;

    onset_detector #(
        .onset_threshold(onset_threshold)
    ) u_onset (
        .audio_in(audio_in),
        .is_onset(is_onset)
    );

    // State register
    always_ff @(posedge audio_clk) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_capture) state_next = ARMED;
            end
            ARMED: begin
                if (audio_trigger) begin
                    if (is_onset) begin
                        state_next = (last_sample == 17'd0) ? DONE : RECORDING;
                    end else if (delay_count_reg == last_delay) begin
                        state_next = IDLE;
                    end
                end
            end
            RECORDING: begin
                if (audio_trigger && (sample_count_reg == last_sample)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_reg == ARMED) || (state_reg == RECORDING);
    end

    // Datapath: counters, write port and status flags
    always_comb begin
        delay_count_next  = delay_count_reg;
        sample_count_next = sample_count_reg;
        write_addr_next   = write_addr_reg;
        write_data_next   = write_data_reg;
        write_enable_next = 1'b0;
        delay_length_next = delay_length_reg;
        complete_next     = complete_reg;
        timeout_next      = timeout_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_capture) begin
                    complete_next     = 1'b0;
                    timeout_next      = 1'b0;
                    delay_count_next  = '0;
                    sample_count_next = '0;
                end
            end
            ARMED: begin
                if (audio_trigger) begin
                    if (is_onset) begin
                        write_enable_next = 1'b1;
                        write_addr_next   = '0;
                        write_data_next   = audio_in;
                        delay_length_next = (delay_count_reg == '0) ? 16'd1 : delay_count_reg;
                        sample_count_next = 17'd1;
                        complete_next     = (last_sample == 17'd0);
                    end else if (delay_count_reg == last_delay) begin
                        timeout_next = 1'b1;
                    end else begin
                        delay_count_next = delay_count_reg + 16'd1;
                    end
                end
            end
            RECORDING: begin
                if (audio_trigger) begin
                    write_enable_next = 1'b1;
                    write_addr_next   = sample_count_reg[SAMPLE_W-1:0];
                    write_data_next   = audio_in;
                    sample_count_next = sample_count_reg + 17'd1;
                    if (sample_count_reg == last_sample) complete_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge audio_clk) begin
        if (!rst_in) begin
            delay_count_reg  <= '0;
            sample_count_reg <= '0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
            write_enable_reg <= 1'b0;
            delay_length_reg <= '0;
            complete_reg     <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            delay_count_reg  <= delay_count_next;
            sample_count_reg <= sample_count_next;
            write_addr_reg   <= write_addr_next;
            write_data_reg   <= write_data_next;
            write_enable_reg <= write_enable_next;
            delay_length_reg <= delay_length_next;
            complete_reg     <= complete_next;
            timeout_reg      <= timeout_next;
        end
    end

    assign write_addr                 = write_addr_reg;
    assign write_data                 = write_data_reg;
    assign write_enable               = write_enable_reg;
    assign delay_length               = delay_length_reg;
    assign impulse_in_memory_complete = complete_reg;
    assign capture_timeout            = timeout_reg;

endmodule

// File: tb/tb_impulse_capture.sv
// Directed vector bench for impulse_capture (impulse_length=8, threshold=1000, max_delay=16).
module tb_impulse_capture;

    logic               audio_clk = 1'b0;
    logic               rst_in = 1'b0;
    logic               start_capture = 1'b0;
    logic               audio_trigger = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic [15:0]        write_addr;
    logic signed [15:0] write_data;
    logic               write_enable;
    logic [15:0]        delay_length;
    logic               impulse_in_memory_complete;
    logic               capture_timeout;
    logic               busy;

    always #5 audio_clk = ~audio_clk;

    impulse_capture #(
        .impulse_length (8),
        .onset_threshold(16'd1000),
        .max_delay      (16'd16)
    ) dut (
        .audio_clk                 (audio_clk),
        .rst_in                    (rst_in),
        .start_capture             (start_capture),
        .audio_trigger             (audio_trigger),
        .audio_in                  (audio_in),
        .write_addr                (write_addr),
        .write_data                (write_data),
        .write_enable              (write_enable),
        .delay_length              (delay_length),
        .impulse_in_memory_complete(impulse_in_memory_complete),
        .capture_timeout           (capture_timeout),
        .busy                      (busy)
    );

    typedef struct {
        logic start;
        logic trig;
        int   sample;
        logic we;
        int   addr;
        int   data;
        int   dl;
        logic cmp;
        logic to;
        logic bsy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic s, input logic t, input int smp, input logic we,
                                input int a, input int d, input int dl, input logic c,
                                input logic to, input logic b);
        vec_t v;
        v.start = s; v.trig = t; v.sample = smp; v.we = we; v.addr = a;
        v.data = d; v.dl = dl; v.cmp = c; v.to = to; v.bsy = b;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic apply(input logic s, input logic t, input int smp);
        @(negedge audio_clk);
        start_capture = s;
        audio_trigger = t;
        audio_in      = 16'(smp);
        @(posedge audio_clk);
        #1;
        start_capture = 1'b0;
        audio_trigger = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic we, input int a, input int d,
                             input int dl, input logic c, input logic to, input logic b);
        chk({tag, ".we"}, int'(write_enable), int'(we));
        chk({tag, ".addr"}, int'(write_addr), a);
        chk({tag, ".data"}, int'(write_data), d);
        chk({tag, ".delay"}, int'(delay_length), dl);
        chk({tag, ".complete"}, int'(impulse_in_memory_complete), int'(c));
        chk({tag, ".timeout"}, int'(capture_timeout), int'(to));
        chk({tag, ".busy"}, int'(busy), int'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a_smp[7];
        a_smp = '{100, -200, 300, -400, 500, -600, 700};

        // Idle with triggers: nothing happens
        for (int i = 0; i < 10; i++) add(0, 1, 5000, 0, 0, 0, 0, 0, 0, 0);
        // Capture A: start coinciding with a loud trigger must not evaluate it
        add(1, 1, 3000, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 10, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, -20, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1500, 1, 0, 1500, 3, 0, 0, 1);
        for (int k = 1; k <= 7; k++) add(0, 1, a_smp[k-1], 1, k, a_smp[k-1], 3, k == 7, 0, k != 7);
        add(0, 1, 1234, 0, 7, 700, 3, 1, 0, 0);
        add(0, 0, 0, 0, 7, 700, 3, 1, 0, 0);
        // Capture B: immediate onset, delay clamped to 1, start mid-recording ignored
        add(1, 0, 0, 0, 7, 700, 3, 0, 0, 1);
        add(0, 1, -1000, 1, 0, -1000, 1, 0, 0, 1);
        for (int k = 1; k <= 7; k++) add(k == 3, 1, k, 1, k, k, 1, k == 7, 0, k != 7);
        // Capture C: most negative sample is an onset
        add(1, 0, 0, 0, 7, 7, 1, 0, 0, 1);
        add(0, 1, -32768, 1, 0, -32768, 1, 0, 0, 1);
        for (int k = 1; k <= 7; k++) add(0, 1, 9, 1, k, 9, 1, k == 7, 0, k != 7);
        // Capture D: 16 just-below-threshold samples time out
        add(1, 0, 0, 0, 7, 9, 1, 0, 0, 1);
        for (int k = 1; k <= 16; k++) add(0, 1, (k % 2 == 1) ? 999 : -999, 0, 7, 9, 1, 0, k == 16, k != 16);
        add(0, 1, 5000, 0, 7, 9, 1, 0, 1, 0);
        add(1, 0, 0, 0, 7, 9, 1, 0, 0, 1);
        add(0, 1, 999, 0, 7, 9, 1, 0, 0, 1);

        // Reset state, including start/trigger asserted while reset is held
        apply(0, 0, 0);
        apply(1, 1, 5000);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        $display("reset: outputs we=%0b addr=%0d busy=%0b", write_enable, write_addr, busy);
        @(negedge audio_clk);
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].start, vecs[i].trig, vecs[i].sample);
            $display("vec %0d: start=%0b trig=%0b in=%0d -> we=%0b addr=%0d data=%0d dly=%0d cmp=%0b to=%0b busy=%0b",
                     i, vecs[i].start, vecs[i].trig, vecs[i].sample, write_enable, write_addr,
                     write_data, delay_length, impulse_in_memory_complete, capture_timeout, busy);
            check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dl,
                      vecs[i].cmp, vecs[i].to, vecs[i].bsy);
        end

        // Armed with delay count 1: onset then addresses 1..3, then reset mid-recording
        apply(0, 1, 2000);
        $display("rec: we=%0b addr=%0d data=%0d", write_enable, write_addr, write_data);
        check_all("rec0", 1, 0, 2000, 1, 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            apply(0, 1, 10 + k);
            $display("rec: we=%0b addr=%0d data=%0d", write_enable, write_addr, write_data);
            chk($sformatf("rec%0d.we", k), int'(write_enable), 1);
            chk($sformatf("rec%0d.addr", k), int'(write_addr), k);
            chk($sformatf("rec%0d.data", k), int'(write_data), 10 + k);
        end
        @(negedge audio_clk);
        rst_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 14 + k);
            $display("abort %0d: we=%0b busy=%0b", k, write_enable, busy);
            check_all($sformatf("abort%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge audio_clk);
        rst_in = 1'b1;
        apply(0, 1, 15);
        $display("post-reset idle: we=%0b busy=%0b", write_enable, busy);
        check_all("postrst_idle", 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0);
        $display("post-reset start: busy=%0b", busy);
        check_all("postrst_start", 0, 0, 0, 0, 0, 0, 1);
        apply(0, 1, 4000);
        $display("recapture: we=%0b addr=%0d data=%0d dly=%0d", write_enable, write_addr, write_data, delay_length);
        check_all("recap0", 1, 0, 4000, 1, 0, 0, 1);
        apply(0, 1, -4000);
        $display("recapture: we=%0b addr=%0d data=%0d", write_enable, write_addr, write_data);
        check_all("recap1", 1, 1, -4000, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
